// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port synchronous memory.
//
// The CPU data port normally wins contention; the debug/loader port is granted
// whenever it is alone, and wins the next contention once it has been denied
// STARVE_MAX consecutive cycles. A small FSM tracks outstanding debug reads so
// dbg_rvalid marks the cycle where mem_rdata belongs to the debug master.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   cpu_req/we/addr/wdata  in          CPU access request
//   cpu_rdata              out         raw mem_rdata (CPU samples it itself)
//   cpu_stall              out         CPU requested but was not granted
//   dbg_req/we/addr/wdata  in          debug access request
//   dbg_gnt                out         debug request accepted this cycle
//   dbg_rvalid, dbg_rdata  out         debug read return
//   mem_en/we/addr/wdata   out         memory command (winner's fields)
//   mem_rdata              in          memory read data, one cycle latency
//
// Read-return FSM
//   state   | meaning
//   RD_IDLE | no debug read data due this cycle
//   RD_DBG  | mem_rdata this cycle answers last cycle's debug read
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {RD_IDLE, RD_DBG} rd_state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  rd_state_t  rd_q, rd_d;
  logic [3:0] starve_q, starve_d;
  logic       prio_q, prio_d;
  logic       grant_cpu, grant_dbg;

  // Grants are qualified with rst_n so every output except cpu_rdata is
  // forced low while reset is held, even with requests active.
  assign grant_cpu = rst_n & cpu_req & ~(dbg_req & prio_q);
  assign grant_dbg = rst_n & dbg_req & ~(cpu_req & ~prio_q);

  assign mem_en     = grant_cpu | grant_dbg;
  assign cpu_stall  = rst_n & cpu_req & ~grant_cpu;
  assign dbg_gnt    = grant_dbg;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rvalid = (rd_q == RD_DBG);
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (grant_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Starve counter counts consecutive denied debug cycles; priority is latched
  // when the count reaches the limit and held until the debug port is served,
  // even if it withdraws its request in between.
  always_comb begin
    starve_d = 4'd0;
    prio_d   = prio_q;
    if (dbg_req && !grant_dbg) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end
    if (grant_dbg) begin
      prio_d = 1'b0;
    end else if (starve_d == STARVE_LIM) begin
      prio_d = 1'b1;
    end
  end

  always_comb begin
    rd_d = rd_q;
    case (rd_q)
      RD_IDLE: if (grant_dbg && !dbg_we) rd_d = RD_DBG;
      RD_DBG:  rd_d = (grant_dbg && !dbg_we) ? RD_DBG : RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= RD_IDLE;
      starve_q <= 4'd0;
      prio_q   <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      starve_q <= starve_d;
      prio_q   <= prio_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd, mr;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall, e_gnt, e_rv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] mr);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    mem_rdata = mr;
  endtask

  task automatic addv(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                      input logic [31:0] mr,
                      input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic st, input logic gnt, input logic rv, input logic [31:0] drd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
    v.e_en = en; v.e_we = we; v.e_addr = addr; v.e_wdata = wd;
    v.e_stall = st; v.e_gnt = gnt; v.e_rv = rv; v.e_drd = drd;
    vecs.push_back(v);
  endtask

  // Behavioural reference state: length of the current denied-debug run,
  // whether debug is owed the next contention, and whether a debug read is due.
  int m_run;
  bit m_owed;
  bit m_rd_due;

  initial begin
    bit c, d, dwin, cwin, stall_prev;
    logic [31:0] rd;

    set_in(1, 0, 32'h40, 0, 1, 0, 32'h100, 0, 32'h5A5A5A5A);
    rst_n = 1'b0;
    #2;
    chk("reset_mem_en", {31'd0, mem_en}, 0);
    chk("reset_stall", {31'd0, cpu_stall}, 0);
    chk("reset_gnt", {31'd0, dbg_gnt}, 0);
    chk("reset_cpu_rdata", cpu_rdata, 32'h5A5A5A5A);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //   cpu: req we addr wdata | dbg: req we addr wdata | mem_rdata | expected outputs
    addv(1,0,32'h40,0,        0,0,0,0,            32'h0,       1,0,32'h40,0,    0,0,0,0);
    addv(0,0,0,0,             0,0,0,0,            32'h12345678,0,0,0,0,         0,0,0,0);
    addv(1,0,32'h80,0,        1,1,32'h200,32'h55, 32'h0,       1,0,32'h80,0,    0,0,0,0);
    addv(1,0,32'h80,0,        1,1,32'h200,32'h55, 32'h0,       1,0,32'h80,0,    0,0,0,0);
    addv(1,0,32'h80,0,        1,1,32'h200,32'h55, 32'h0,       1,0,32'h80,0,    0,0,0,0);
    addv(1,0,32'h80,0,        1,1,32'h200,32'h55, 32'h0,       1,0,32'h80,0,    0,0,0,0);
    addv(1,0,32'h80,0,        1,1,32'h200,32'h55, 32'h0,       1,1,32'h200,32'h55,1,1,0,0);
    addv(1,0,32'h80,0,        1,1,32'h200,32'h55, 32'h0,       1,0,32'h80,0,    0,0,0,0);
    addv(0,0,0,0,             0,0,0,0,            32'h0,       0,0,0,0,         0,0,0,0);
    addv(0,0,0,0,             1,0,32'h100,0,      32'h0,       1,0,32'h100,0,   0,1,0,0);
    addv(0,0,0,0,             0,0,0,0,            32'hDEADBEEF,0,0,0,0,         0,0,1,32'hDEADBEEF);
    addv(0,0,0,0,             0,0,0,0,            32'h11111111,0,0,0,0,         0,0,0,0);
    addv(0,0,0,0,             1,0,32'h8,0,        32'h0,       1,0,32'h8,0,     0,1,0,0);
    addv(0,0,0,0,             1,0,32'hC,0,        32'hA0,      1,0,32'hC,0,     0,1,1,32'hA0);
    addv(0,0,0,0,             0,0,0,0,            32'hB0,      0,0,0,0,         0,0,1,32'hB0);
    addv(0,0,0,0,             0,0,0,0,            32'hC0,      0,0,0,0,         0,0,0,0);
    addv(0,0,0,0,             1,1,32'h20,32'hA5,  32'h0,       1,1,32'h20,32'hA5,0,1,0,0);
    addv(0,0,0,0,             0,0,0,0,            32'h77,      0,0,0,0,         0,0,0,0);
    addv(1,1,32'h44,32'h99,   0,0,0,0,            32'h0,       1,1,32'h44,32'h99,0,0,0,0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      set_in(v.cr, v.cw, v.ca, v.cd, v.dr, v.dw, v.da, v.dd, v.mr);
      #1;
      chk($sformatf("v%0d mem_en", i), {31'd0, mem_en}, {31'd0, v.e_en});
      chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v.e_we});
      chk($sformatf("v%0d mem_addr", i), mem_addr, v.e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.e_wdata);
      chk($sformatf("v%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, v.e_stall});
      chk($sformatf("v%0d dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, v.e_gnt});
      chk($sformatf("v%0d dbg_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, v.e_rv});
      chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, v.e_drd);
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, v.mr);
      @(negedge clk);
    end

    // Build a starve count of 3, then reset in the middle of a debug read return.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 0);
      #1;
      chk($sformatf("pre_rst_gnt%0d", k), {31'd0, dbg_gnt}, 0);
      @(negedge clk);
    end
    chk("starve_at_3", {28'd0, dut.starve_q}, 3);
    set_in(0, 0, 0, 0, 1, 0, 32'h104, 0, 0);
    #1;
    chk("rd_gnt_before_rst", {31'd0, dbg_gnt}, 1);
    @(negedge clk);
    set_in(1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 32'hCAFE);
    #1;
    chk("rvalid_before_rst", {31'd0, dbg_rvalid}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", {31'd0, dbg_rvalid}, 0);
    chk("rst_drdata", dbg_rdata, 0);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", {31'd0, cpu_stall}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 32'hCAFE);
    chk("rst_starve", {28'd0, dut.starve_q}, 0);
    chk("rst_prio", {31'd0, dut.prio_q}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
    #1;
    chk("post_rst_rvalid0", {31'd0, dbg_rvalid}, 0);
    @(negedge clk);
    #1;
    chk("post_rst_rvalid1", {31'd0, dbg_rvalid}, 0);
    @(negedge clk);
    // Fresh starve count after reset: debug must wait the full STARVE_MAX cycles.
    for (int k = 0; k < SMAX + 1; k++) begin
      set_in(1, 0, 32'h300, 0, 1, 1, 32'h400, 32'h1, 0);
      #1;
      chk($sformatf("post_rst_cont%0d", k), {31'd0, dbg_gnt}, (k == SMAX) ? 1 : 0);
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Randomized traffic against the reference model.
    m_run = 0; m_owed = 0; m_rd_due = 0; stall_prev = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!stall_prev) begin
        cpu_req = ($urandom_range(0, 9) < 7);
        cpu_we = $urandom_range(0, 1);
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end
      dbg_req = ($urandom_range(0, 1) == 1);
      dbg_we = $urandom_range(0, 1);
      dbg_addr = $urandom;
      dbg_wdata = $urandom;
      mem_rdata = $urandom;
      c = cpu_req; d = dbg_req;
      dwin = d && (!c || m_owed);
      cwin = c && !dwin;
      rd = m_rd_due ? mem_rdata : 32'h0;
      #1;
      if (cwin != (mem_en && !dbg_gnt) || dwin != dbg_gnt || (c && !cwin) != cpu_stall ||
          m_rd_due != dbg_rvalid || rd != dbg_rdata ||
          (cwin && (mem_addr != cpu_addr || mem_we != cpu_we || mem_wdata != cpu_wdata)) ||
          (dwin && (mem_addr != dbg_addr || mem_we != dbg_we || mem_wdata != dbg_wdata)) ||
          (!cwin && !dwin && (mem_en || mem_addr != 0 || mem_we || mem_wdata != 0))) begin
        total_cnt++;
        $display("FAIL rand cycle %0d: got en=%b gnt=%b stall=%b rv=%b drd=%h expected cpu_win=%b dbg_win=%b rv=%b drd=%h",
                 n, mem_en, dbg_gnt, cpu_stall, dbg_rvalid, dbg_rdata, cwin, dwin, m_rd_due, rd);
      end else begin
        total_cnt++;
        pass_cnt++;
      end
      stall_prev = c && !cwin;
      if (d && !dwin) begin
        m_run = (m_run + 1 > SMAX) ? SMAX : m_run + 1;
        if (m_run == SMAX) m_owed = 1;
      end else begin
        m_run = 0;
      end
      if (dwin) m_owed = 0;
      m_rd_due = dwin && !dbg_we;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
